// File: rtl/vga_timing_gen_pkg.sv
// Shared constants, types and colour helpers for the VGA raster generator.
// Defaults describe 640x480@60 with a 100 MHz board clock.
package vga_timing_gen_pkg;

  localparam int unsigned RES_H        = 640;
  localparam int unsigned RES_V        = 480;
  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          SYNC_POL_DEF = 1'b0;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [7:0]         rgb_t;

  localparam rgb_t RGB_BLACK = 8'h00;

  // RRRGGGBB: each bar-index bit lights one whole colour field.
  function automatic rgb_t bar_colour(input logic [2:0] bar);
    return {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
  endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Modulo-N counter with enable; exposes its next value and a wrap strobe
// so the parent can decode outputs with zero skew against the count.
module vga_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count_reg,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_comb begin
    wrap       = en && (count_reg == LAST);
    count_next = count_reg;
    if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, sync decode, sprite-line
// pre-start pulse. Define VGA_TEST_PATTERN_EN to build the colour-bar output.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned H_VISIBLE = RES_H,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = RES_V,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          SYNC_POL  = SYNC_POL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] spr_y,
  output logic       pix_en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       spr_start,
  output logic [7:0] rgb
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam coord_t H_VIS     = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS     = coord_t'(V_VISIBLE);
  localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t V_LAST    = coord_t'(V_TOT - 1);
  localparam coord_t SPR_X_PRE = coord_t'(H_VISIBLE - 1);

  logic [DIV_W-1:0] divider_reg;
  logic             pix_en_reg;
  coord_t           h_count, h_next;
  coord_t           v_count, v_next;
  logic             h_wrap, v_wrap;

  logic   hsync_reg, vsync_reg, video_on_reg, frame_start_reg, spr_start_reg;
  logic   hs_active, vs_active, video_on_next, spr_hit;
  coord_t spr_line;

  // pix_en is set on the edge that sees the last divider phase, so the
  // first strobe lands CLK_DIV edges after reset release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      divider_reg <= '0;
      pix_en_reg  <= 1'b0;
    end else begin
      pix_en_reg  <= (divider_reg == DIV_LAST);
      divider_reg <= (divider_reg == DIV_LAST) ? '0 : divider_reg + DIV_W'(1);
    end
  end

  vga_counter #(
    .N (H_TOT),
    .W (COORD_W)
  ) u_h_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (pix_en_reg),
    .count_reg  (h_count),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  vga_counter #(
    .N (V_TOT),
    .W (COORD_W)
  ) u_v_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .count_reg  (v_count),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Decode from the next count so the registered flags line up with it.
  always_comb begin
    hs_active     = (h_next >= HS_START) && (h_next <= HS_END);
    vs_active     = (v_next >= VS_START) && (v_next <= VS_END);
    video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
    spr_line      = (spr_y == '0) ? V_LAST : spr_y - coord_t'(1);
    spr_hit       = pix_en_reg && (h_count == SPR_X_PRE) &&
                    (spr_y < V_VIS) && (v_count == spr_line);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
      video_on_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
      spr_start_reg   <= 1'b0;
    end else begin
      hsync_reg       <= hs_active ? SYNC_POL : ~SYNC_POL;
      vsync_reg       <= vs_active ? SYNC_POL : ~SYNC_POL;
      video_on_reg    <= video_on_next;
      frame_start_reg <= h_wrap && v_wrap;
      spr_start_reg   <= spr_hit;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam coord_t BAR_W = coord_t'(H_VISIBLE / 8);

  logic [2:0] bar_idx;
  rgb_t       rgb_reg;

  always_comb begin
    bar_idx = 3'(h_next / BAR_W);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_reg <= RGB_BLACK;
    end else begin
      rgb_reg <= video_on_next ? bar_colour(bar_idx) : RGB_BLACK;
    end
  end

  assign rgb = rgb_reg;
`else
  assign rgb = RGB_BLACK;
`endif

  assign pix_en      = pix_en_reg;
  assign pixel_x     = h_count;
  assign pixel_y     = v_count;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign frame_start = frame_start_reg;
  assign spr_start   = spr_start_reg;

endmodule
